// File: rtl/sparse_stream_profiler.sv
`default_nettype none
// ============================================================================
//  Module      : sparse_stream_profiler
//  Description : Passive profiler for ready/valid stream taps of a sparse core
//                tile. Sequences WRITE -> GAP -> ARM -> READ -> DONE, gates the
//                read side through rd_enable, and reports phase cycle counts
//                plus per-channel transfer/stall counts and token flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module sparse_stream_profiler #(
    parameter int                NUM_CH     = 4,
    parameter int                DATA_W     = 17,
    parameter int                CNT_W      = 32,
    parameter logic [DATA_W-1:0] DONE_TOKEN = 17'h10100,
    parameter int                GAP_CYCLES = 10,
    parameter logic [NUM_CH-1:0] WR_MASK    = 4'b0011
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    flush,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]       ch_valid,
    input  logic [NUM_CH-1:0]       ch_ready,
    output logic                    rd_enable,
    output logic [2:0]              phase,
    output logic [CNT_W-1:0]        wr_cycles,
    output logic [CNT_W-1:0]        rd_cycles,
    output logic [NUM_CH*CNT_W-1:0] ch_xfer_cnt,
    output logic [NUM_CH*CNT_W-1:0] ch_stall_cnt,
    output logic [NUM_CH-1:0]       ch_done,
    output logic                    all_done
);

    localparam logic [NUM_CH-1:0] c_RD_MASK = ~WR_MASK;
    localparam int                c_GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    // Reject configurations that could never complete a phase
    generate
        if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
            $error("sparse_stream_profiler: NUM_CH must be in 2..16");
        end
        if (WR_MASK == '0 || c_RD_MASK == '0) begin : g_bad_mask
            $error("sparse_stream_profiler: both write and read channel sets must be nonempty");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_GAP   = 3'd2,
        S_ARM   = 3'd3,
        S_READ  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_GAP_W-1:0]   r_gap_cnt;
    logic [CNT_W-1:0]     r_wr_cycles;
    logic [CNT_W-1:0]     r_rd_cycles;
    logic [NUM_CH-1:0]    r_done;
    logic [NUM_CH-1:0]    w_fire;
    logic [NUM_CH-1:0]    w_tok;
    logic [NUM_CH-1:0]    w_live;
    logic [NUM_CH-1:0]    w_done_nxt;

    assign w_fire     = ch_valid & ch_ready;
    // Flags updated this cycle take part in the phase-exit decision
    assign w_done_nxt = r_done | (w_live & w_tok);

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [CNT_W-1:0] r_xfer;
            logic [CNT_W-1:0] r_stall;

            assign w_tok[i]  = w_fire[i] && (ch_data[i*DATA_W +: DATA_W] == DONE_TOKEN);
            assign w_live[i] = WR_MASK[i] ? (r_state == S_WRITE) : (r_state == S_READ);

            // Saturating handshake and stall counters, active only while live
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    r_xfer  <= '0;
                    r_stall <= '0;
                end else if (clk_en && w_live[i]) begin
                    if (w_fire[i] && r_xfer != '1)
                        r_xfer <= r_xfer + 1'b1;
                    if (ch_valid[i] && !ch_ready[i] && r_stall != '1)
                        r_stall <= r_stall + 1'b1;
                end
            end

            assign ch_xfer_cnt[i*CNT_W +: CNT_W]  = r_xfer;
            assign ch_stall_cnt[i*CNT_W +: CNT_W] = r_stall;
        end
    endgenerate

    // Next-phase decision
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if ((ch_valid & WR_MASK) != '0)            w_state_nxt = S_WRITE;
            S_WRITE: if ((w_done_nxt & WR_MASK) == WR_MASK)     w_state_nxt = S_GAP;
            S_GAP:   if (r_gap_cnt == '0)                        w_state_nxt = S_ARM;
            S_ARM:   if ((ch_valid & c_RD_MASK) != '0)           w_state_nxt = S_READ;
            S_READ:  if ((w_done_nxt & c_RD_MASK) == c_RD_MASK) w_state_nxt = S_DONE;
            default:                                             w_state_nxt = r_state;
        endcase
    end

    // Phase register, settle-gap down-counter, phase cycle counters and token flags
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state     <= S_IDLE;
            r_gap_cnt   <= '0;
            r_wr_cycles <= '0;
            r_rd_cycles <= '0;
            r_done      <= '0;
        end else if (clk_en) begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            if (r_state == S_WRITE && w_state_nxt == S_GAP)
                r_gap_cnt <= c_GAP_W'(GAP_CYCLES);
            else if (r_state == S_GAP && r_gap_cnt != '0)
                r_gap_cnt <= r_gap_cnt - 1'b1;
            if (r_state == S_WRITE && r_wr_cycles != '1)
                r_wr_cycles <= r_wr_cycles + 1'b1;
            if (r_state == S_READ && r_rd_cycles != '1)
                r_rd_cycles <= r_rd_cycles + 1'b1;
        end
    end

    assign phase     = r_state;
    assign rd_enable = (r_state == S_READ) || (r_state == S_DONE);
    assign all_done  = (r_state == S_DONE);
    assign wr_cycles = r_wr_cycles;
    assign rd_cycles = r_rd_cycles;
    assign ch_done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sparse_stream_profiler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sparse_stream_profiler
//  Description : Directed bench for sparse_stream_profiler (default build plus
//                a GAP_CYCLES=0 / CNT_W=4 build) with a cycle-stamped
//                expected-value queue drained by an independent monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sparse_stream_profiler;

    localparam logic [16:0] c_TOKEN = 17'h10100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b1;
    logic        flush = 1'b0;
    logic        flush2 = 1'b0;
    logic [3:0]  v = '0, r = '0, v2 = '0, r2 = '0;
    logic [16:0] d  [4];
    logic [16:0] d2 [4];
    logic [67:0] ch_data, ch_data2;

    logic         rd_enable, all_done;
    logic [2:0]   phase;
    logic [31:0]  wr_cycles, rd_cycles;
    logic [127:0] xfer, stall;
    logic [3:0]   ch_done;

    logic         rd_enable2, all_done2;
    logic [2:0]   phase2;
    logic [3:0]   wr2, rd2;
    logic [15:0]  xfer2, stall2;
    logic [3:0]   done2;

    assign ch_data  = {d[3], d[2], d[1], d[0]};
    assign ch_data2 = {d2[3], d2[2], d2[1], d2[0]};

    always #5 clk = ~clk;

    sparse_stream_profiler dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush),
        .ch_data(ch_data), .ch_valid(v), .ch_ready(r),
        .rd_enable(rd_enable), .phase(phase), .wr_cycles(wr_cycles), .rd_cycles(rd_cycles),
        .ch_xfer_cnt(xfer), .ch_stall_cnt(stall), .ch_done(ch_done), .all_done(all_done)
    );

    sparse_stream_profiler #(.CNT_W(4), .GAP_CYCLES(0)) dut2 (
        .clk(clk), .rst(rst), .clk_en(1'b1), .flush(flush2),
        .ch_data(ch_data2), .ch_valid(v2), .ch_ready(r2),
        .rd_enable(rd_enable2), .phase(phase2), .wr_cycles(wr2), .rd_cycles(rd2),
        .ch_xfer_cnt(xfer2), .ch_stall_cnt(stall2), .ch_done(done2), .all_done(all_done2)
    );

    typedef struct {
        int          cyc;
        int          sel;
        int          ch;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] get(int sel, int ch);
        case (sel)
            0:  return 32'(phase);
            1:  return 32'(rd_enable);
            2:  return wr_cycles;
            3:  return rd_cycles;
            4:  return xfer[ch*32 +: 32];
            5:  return stall[ch*32 +: 32];
            6:  return 32'(ch_done);
            7:  return 32'(all_done);
            8:  return 32'(phase2);
            9:  return 32'(xfer2[ch*4 +: 4]);
            10: return 32'(wr2);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: compare every expectation stamped for the current cycle
    initial begin
        exp_t        e;
        logic [31:0] got;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e   = sb.pop_front();
                got = get(e.sel, e.ch);
                checks++;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %0h expected %0h (cycle %0d)", e.name, got, e.val, cyc);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, int sel, int ch, logic [31:0] val);
        exp_t e;
        e.cyc = cyc; e.sel = sel; e.ch = ch; e.val = val; e.name = nm;
        sb.push_back(e);
    endtask

    // Enter WRITE with ready low, then 5 words + token on ch0/ch1; ch0 stalls before word 3
    task automatic do_write(int stalls);
        v = 4'b0011; r = 4'b0000; d[0] = 17'h1; d[1] = 17'h1;
        tick();
        chk("enter_write", 0, 0, 1);
        for (int k = 0; k < 6; k++) begin
            if (k == 2) begin
                for (int s = 0; s < stalls; s++) begin
                    v = 4'b0001; r = 4'b0000;
                    tick();
                end
            end
            v = 4'b0011; r = 4'b0011;
            d[0] = (k == 5) ? c_TOKEN : 17'(k + 1);
            d[1] = (k == 5) ? c_TOKEN : 17'(k + 1);
            tick();
            if (k == 4) chk("write_hold", 0, 0, 1);
        end
        v = '0; r = '0;
        chk("write_to_gap", 0, 0, 2);
        chk("wr_cycles", 2, 0, 32'(6 + stalls));
        chk("xfer0", 4, 0, 6);
        chk("xfer1", 4, 1, 6);
        chk("stall0", 5, 0, 32'(stalls));
        chk("stall1", 5, 1, 0);
        chk("wr_done_flags", 6, 0, 32'h3);
    endtask

    // GAP already seen once on entry; 10 more cycles of GAP, then ARM
    task automatic do_gap();
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("gap_hold", 0, 0, 2);
        end
        tick();
        chk("gap_to_arm", 0, 0, 3);
        chk("arm_rd_enable", 1, 0, 0);
    endtask

    // mode 0: plain read, 1: clk_en freeze mid-READ, 2: flush mid-READ
    task automatic do_read(int mode);
        v = 4'b1100; r = 4'b0000; d[2] = 17'h20; d[3] = 17'h20;
        tick();
        chk("enter_read", 0, 0, 4);
        chk("read_rd_enable", 1, 0, 1);
        r = 4'b1100;
        for (int k = 0; k < 5; k++) begin
            if (k == 2 && mode == 1) begin
                clk_en = 1'b0; d[2] = c_TOKEN; d[3] = c_TOKEN;
                for (int f = 0; f < 4; f++) tick();
                chk("freeze_phase", 0, 0, 4);
                chk("freeze_rd_cycles", 3, 0, 2);
                chk("freeze_xfer2", 4, 2, 2);
                chk("freeze_done", 6, 0, 32'h3);
                clk_en = 1'b1;
            end
            if (k == 2 && mode == 2) begin
                flush = 1'b1;
                tick();
                flush = 1'b0; v = '0; r = '0;
                chk("flush_phase", 0, 0, 0);
                chk("flush_wr_cycles", 2, 0, 0);
                chk("flush_rd_cycles", 3, 0, 0);
                chk("flush_xfer0", 4, 0, 0);
                chk("flush_xfer2", 4, 2, 0);
                chk("flush_stall0", 5, 0, 0);
                chk("flush_done", 6, 0, 0);
                chk("flush_rd_enable", 1, 0, 0);
                return;
            end
            d[2] = (k == 4) ? c_TOKEN : 17'(17'h21 + k);
            d[3] = (k == 4) ? c_TOKEN : 17'(17'h21 + k);
            tick();
            if (k == 3) chk("read_hold", 0, 0, 4);
        end
        v = '0; r = '0;
        chk("read_to_done", 0, 0, 5);
        chk("rd_cycles", 3, 0, 5);
        chk("xfer2", 4, 2, 5);
        chk("xfer3", 4, 3, 5);
        chk("all_flags", 6, 0, 32'hF);
        chk("all_done", 7, 0, 1);
        chk("done_rd_enable", 1, 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            d[i] = '0;
            d2[i] = '0;
        end

        // Reset hold with random traffic
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            v = 4'($urandom); r = 4'($urandom);
            for (int i = 0; i < 4; i++) d[i] = 17'($urandom);
            tick();
            chk("rst_phase", 0, 0, 0);
            chk("rst_wr_cycles", 2, 0, 0);
            chk("rst_xfer0", 4, 0, 0);
            chk("rst_stall0", 5, 0, 0);
            chk("rst_rd_enable", 1, 0, 0);
        end
        v = '0; r = '0; rst = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = '0;
        tick();
        chk("idle_after_rst", 0, 0, 0);

        // Run 1: nominal with clk_en freeze mid-READ, then DONE must hold
        do_write(0);
        do_gap();
        do_read(1);
        v = 4'b0011; r = 4'b0011;
        tick();
        tick();
        v = '0; r = '0;
        chk("done_holds", 0, 0, 5);
        chk("done_rd_cycles_hold", 3, 0, 5);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_from_done", 0, 0, 0);

        // Run 2: backpressure on ch0, flush mid-READ
        do_write(3);
        do_gap();
        do_read(2);

        // Run 3: nominal numbers reproduced after flush
        do_write(0);
        do_gap();
        do_read(0);

        // Reduced build: saturation at 15 and single-cycle GAP
        v2 = 4'b0011; r2 = 4'b0000; d2[0] = 17'h5; d2[1] = 17'h5;
        tick();
        chk("s_enter_write", 8, 0, 1);
        v2 = 4'b0001; r2 = 4'b0001;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k == 14) chk("s_xfer_at_15", 9, 0, 15);
        end
        chk("s_xfer_saturated", 9, 0, 15);
        chk("s_wr_saturated", 10, 0, 15);
        v2 = 4'b0011; r2 = 4'b0011; d2[0] = c_TOKEN; d2[1] = c_TOKEN;
        tick();
        v2 = '0; r2 = '0;
        chk("s_to_gap", 8, 0, 2);
        chk("s_xfer_after_tok", 9, 0, 15);
        chk("s_xfer1", 9, 1, 1);
        tick();
        chk("s_gap_one_cycle", 8, 0, 3);

        tick();
        tick();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
